// File: rtl/doorway_direction_detector.sv
`default_nettype none
// ============================================================================
// Module   : doorway_direction_detector
// Purpose  : Two-beam doorway front end; synchronises, debounces and decodes
//            pass order into one-cycle enter/exit/fault pulses.
// Revision : 1.0 - initial release
// ============================================================================
module doorway_direction_detector #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic beam_outer,
    input  logic beam_inner,
    output logic enter_pulse,
    output logic exit_pulse,
    output logic fault_pulse,
    output logic busy
);

    localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_E1   = 3'd1,
        S_E2   = 3'd2,
        S_E3   = 3'd3,
        S_X1   = 3'd4,
        S_X2   = 3'd5,
        S_X3   = 3'd6,
        S_WAIT = 3'd7
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_deb;

    assign w_raw = {beam_inner, beam_outer};

    // Bit 0 is the outer beam, bit 1 the inner beam.
    for (genvar b = 0; b < 2; b++) begin : g_beam
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_DB_W-1:0]      r_cnt;
        logic                   r_deb;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_deb  <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[b]};
                if (r_sync[SYNC_STAGES-1] != r_deb) begin
                    if (r_cnt == c_DB_LAST) begin
                        r_deb <= r_sync[SYNC_STAGES-1];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_deb[b] = r_deb;
    end

    state_t            r_state;
    logic [c_TO_W-1:0] r_tmo;
    logic              r_enter;
    logic              r_exit;
    logic              r_fault;
    logic              r_busy;

    state_t w_next;
    logic   w_enter;
    logic   w_exit;
    logic   w_fault;
    logic   w_hold;
    logic   w_o;
    logic   w_i;

    assign w_o = w_deb[0];
    assign w_i = w_deb[1];

    always_comb begin
        w_next  = r_state;
        w_enter = 1'b0;
        w_exit  = 1'b0;
        w_fault = 1'b0;
        w_hold  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_o & ~w_i)      w_next = S_E1;
                else if (~w_o & w_i) w_next = S_X1;
                else if (w_o & w_i) begin w_next = S_WAIT; w_fault = 1'b1; end
            end
            S_E1: begin
                if (w_o & w_i)        w_next = S_E2;
                else if (~w_o & w_i)  w_next = S_E3;
                else if (~w_o & ~w_i) w_next = S_IDLE;
                else                  w_hold = 1'b1;
            end
            S_E2: begin
                if (w_o & ~w_i)       w_next = S_E1;
                else if (~w_o & w_i)  w_next = S_E3;
                else if (~w_o & ~w_i) begin w_next = S_IDLE; w_fault = 1'b1; end
                else                  w_hold = 1'b1;
            end
            S_E3: begin
                if (~w_o & ~w_i)      begin w_next = S_IDLE; w_enter = 1'b1; end
                else if (w_o & w_i)   w_next = S_E2;
                else if (w_o & ~w_i)  w_next = S_E1;
                else                  w_hold = 1'b1;
            end
            S_X1: begin
                if (w_o & w_i)        w_next = S_X2;
                else if (w_o & ~w_i)  w_next = S_X3;
                else if (~w_o & ~w_i) w_next = S_IDLE;
                else                  w_hold = 1'b1;
            end
            S_X2: begin
                if (~w_o & w_i)       w_next = S_X1;
                else if (w_o & ~w_i)  w_next = S_X3;
                else if (~w_o & ~w_i) begin w_next = S_IDLE; w_fault = 1'b1; end
                else                  w_hold = 1'b1;
            end
            S_X3: begin
                if (~w_o & ~w_i)      begin w_next = S_IDLE; w_exit = 1'b1; end
                else if (w_o & w_i)   w_next = S_X2;
                else if (~w_o & w_i)  w_next = S_X1;
                else                  w_hold = 1'b1;
            end
            S_WAIT: begin
                if (~w_o & ~w_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Timeout only fires when no legal transition was taken this edge.
        if (w_hold && (r_tmo == c_TO_LAST)) begin
            w_next  = S_WAIT;
            w_fault = 1'b1;
            w_hold  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tmo   <= w_hold ? r_tmo + 1'b1 : '0;
            r_enter <= w_enter;
            r_exit  <= w_exit;
            r_fault <= w_fault;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    assign enter_pulse = r_enter;
    assign exit_pulse  = r_exit;
    assign fault_pulse = r_fault;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_doorway_direction_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_doorway_direction_detector
// Purpose  : Scoreboard bench; expected pulses are queued with their due cycle
//            when the releasing stimulus is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_doorway_direction_detector;

    logic clk = 1'b0;
    logic rst;
    logic beam_outer;
    logic beam_inner;
    logic enter_pulse;
    logic exit_pulse;
    logic fault_pulse;
    logic busy;

    doorway_direction_detector #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .beam_outer (beam_outer),
        .beam_inner (beam_inner),
        .enter_pulse(enter_pulse),
        .exit_pulse (exit_pulse),
        .fault_pulse(fault_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam int c_LAT = 7;  // raw change -> visible FSM effect
    localparam int c_ENTER = 0;
    localparam int c_EXIT  = 1;
    localparam int c_FAULT = 2;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mon_kind;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0 && (enter_pulse === 1'b1 || exit_pulse === 1'b1 || fault_pulse === 1'b1)) begin
            mon_kind = (enter_pulse === 1'b1) ? c_ENTER : (exit_pulse === 1'b1) ? c_EXIT : c_FAULT;
            n_checks++;
            if (int'(enter_pulse) + int'(exit_pulse) + int'(fault_pulse) > 1) begin
                n_fail++;
                $display("FAIL pulse_exclusive cyc=%0d got e/x/f=%b%b%b required one-hot",
                         cyc, enter_pulse, exit_pulse, fault_pulse);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse kind=%0d cyc=%0d required no pulse", mon_kind, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.kind !== mon_kind || mon_e.at !== cyc) begin
                    n_fail++;
                    $display("FAIL pulse_match got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                             mon_kind, cyc, mon_e.kind, mon_e.at);
                end
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        beam_outer = 1'b0;
        beam_inner = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, enter_pulse, exit_pulse, fault_pulse} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got b/e/x/f=%b%b%b%b required 0000",
                     busy, enter_pulse, exit_pulse, fault_pulse);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b required 0", busy);
        end
    endtask

    task automatic test_entry();
        int n;
        n = cyc;
        beam_outer = 1'b1;
        wait_until(n + 20); beam_inner = 1'b1;
        wait_until(n + 40); beam_outer = 1'b0;
        wait_until(n + 50);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL entry_busy_mid got %b required 1", busy); end
        wait_until(n + 60); beam_inner = 1'b0;
        sb.push_back('{c_ENTER, cyc + c_LAT});
        wait_until(n + 66);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL entry_busy_before got %b required 1", busy); end
        wait_until(n + 67);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL entry_busy_drop got %b required 0", busy); end
        wait_until(n + 80);
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL entry_missing got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_exit();
        int n;
        n = cyc;
        beam_inner = 1'b1;
        wait_until(n + 20); beam_outer = 1'b1;
        wait_until(n + 40); beam_inner = 1'b0;
        wait_until(n + 60); beam_outer = 1'b0;
        sb.push_back('{c_EXIT, cyc + c_LAT});
        wait_until(n + 67);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL exit_busy_drop got %b required 0", busy); end
        wait_until(n + 80);
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL exit_missing got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_backout();
        int n;
        n = cyc;
        beam_outer = 1'b1;
        wait_until(n + 6);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL backout_busy_early got %b required 0", busy); end
        wait_until(n + 7);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL backout_busy_rise got %b required 1", busy); end
        wait_until(n + 20); beam_outer = 1'b0;
        wait_until(n + 26);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL backout_busy_hold got %b required 1", busy); end
        wait_until(n + 27);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL backout_busy_fall got %b required 0", busy); end
        // Hesitant exit: X1, X2, X3, back to X2, X3, then clear.
        n = n + 40;
        wait_until(n);      beam_inner = 1'b1;
        wait_until(n + 20); beam_outer = 1'b1;
        wait_until(n + 40); beam_inner = 1'b0;
        wait_until(n + 60); beam_inner = 1'b1;
        wait_until(n + 80); beam_inner = 1'b0;
        wait_until(n + 100); beam_outer = 1'b0;
        sb.push_back('{c_EXIT, cyc + c_LAT});
        wait_until(n + 120);
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL backout_exit_missing got %0d pending required 0", sb.size()); end
    endtask

    task automatic test_glitch();
        int n;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 13; c++) begin
                beam_outer = (c < 3);
                @(negedge clk);
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL glitch_busy k=%0d c=%0d got %b required 0", k, c, busy);
                end
            end
        end
        n = cyc;
        beam_outer = 1'b1;
        wait_until(n + 4); beam_outer = 1'b0;
        wait_until(n + 6);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL pulse4_busy_early got %b required 0", busy); end
        wait_until(n + 7);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL pulse4_busy_rise got %b required 1", busy); end
        wait_until(n + 10);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL pulse4_busy_hold got %b required 1", busy); end
        wait_until(n + 11);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL pulse4_busy_fall got %b required 0", busy); end
        wait_until(n + 25);
    endtask

    task automatic test_timeout();
        int n;
        n = cyc;
        beam_outer = 1'b1;
        sb.push_back('{c_FAULT, n + c_LAT + 1000});
        wait_until(n + 500);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_mid got %b required 1", busy); end
        wait_until(n + 1200); beam_outer = 1'b0;
        wait_until(n + 1206);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_wait_busy got %b required 1", busy); end
        wait_until(n + 1207);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_fall got %b required 0", busy); end
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL timeout_missing got %0d pending required 0", sb.size()); end
        wait_until(n + 1220);
    endtask

    task automatic test_reset_mid();
        int n;
        n = cyc;
        beam_outer = 1'b1;
        wait_until(n + 20); beam_inner = 1'b1;
        wait_until(n + 40); beam_outer = 1'b0;
        wait_until(n + 55);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_e3 got %b required 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, enter_pulse, exit_pulse, fault_pulse} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_outputs got b/e/x/f=%b%b%b%b required 0000",
                     busy, enter_pulse, exit_pulse, fault_pulse);
        end
        rst = 1'b0;
        @(negedge clk);
        beam_inner = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after got %b required 0", busy); end
    endtask

    task automatic test_both();
        int n;
        n = cyc;
        beam_outer = 1'b1;
        beam_inner = 1'b1;
        sb.push_back('{c_FAULT, n + c_LAT});
        wait_until(n + 20); beam_outer = 1'b0;
        wait_until(n + 35);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL both_wait_busy got %b required 1", busy); end
        wait_until(n + 40); beam_inner = 1'b0;
        wait_until(n + 46);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL both_busy_hold got %b required 1", busy); end
        wait_until(n + 47);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL both_busy_fall got %b required 0", busy); end
        wait_until(n + 60);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_exit();
        test_backout();
        test_glitch();
        test_timeout();
        test_reset_mid();
        test_both();
        repeat (20) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL final_pending got %0d required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
